// File: rtl/accum_pkg.sv
// accum_pkg: shared state encoding and default widths for the accumulator sequencer
package accum_pkg;
    localparam int WIDTH = 8;
    localparam int CNT_W = 4;
    typedef enum logic [1:0] {IDLE, CLEAR, LOAD, FINISH} state_t;
endpackage

// File: rtl/accum_sequencer_if.sv
// accum_sequencer_if: job control, operand stream and accumulator pins
interface accum_sequencer_if import accum_pkg::*; #(
    parameter int W  = WIDTH,
    parameter int CW = CNT_W
);
    logic          START;
    logic [CW-1:0] COUNT;
    logic          ABORT;
    logic [W-1:0]  DIN;
    logic          DIN_VALID;
    logic          DIN_READY;
    logic          ACC_CLR;
    logic          ACC_LD;
    logic [W-1:0]  ACC_D;
    logic [W-1:0]  ACC_Q;
    logic          BUSY;
    logic          DONE;
    logic [W-1:0]  RESULT;
    logic          OVF;
    modport slave (
        input  START, COUNT, ABORT, DIN, DIN_VALID, ACC_Q,
        output DIN_READY, ACC_CLR, ACC_LD, ACC_D, BUSY, DONE, RESULT, OVF
    );
    modport master (
        output START, COUNT, ABORT, DIN, DIN_VALID, ACC_Q,
        input  DIN_READY, ACC_CLR, ACC_LD, ACC_D, BUSY, DONE, RESULT, OVF
    );
endinterface

// File: rtl/accum_sequencer.sv
// accum_sequencer: drives an external accumulator through one counted summation job
module accum_sequencer import accum_pkg::*; (
    input logic clk,
    input logic RST,
    accum_sequencer_if.slave bus
);
    state_t state, state_nxt;
    logic [CNT_W-1:0] remaining;
    logic sticky;
    logic abort;
    logic carry;
    assign abort = bus.ABORT && state != IDLE;
    // Q + DIN overflows exactly when DIN exceeds the headroom ~Q
    assign carry = bus.DIN > ~bus.ACC_Q;
    always_ff @(posedge clk) begin
        state <= RST ? IDLE : state_nxt;
    end
    always_comb begin
        state_nxt = state;
        if (abort)
            state_nxt = IDLE;
        else
            case (state)
                IDLE:    state_nxt = bus.START ? CLEAR : IDLE;
                CLEAR:   state_nxt = remaining == '0 ? FINISH : LOAD;
                LOAD:    state_nxt = bus.ACC_LD && remaining == CNT_W'(1) ? FINISH : LOAD;
                FINISH:  state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
    end
    always_comb begin
        bus.BUSY      = !RST && state != IDLE;
        bus.DIN_READY = !RST && state == LOAD && !abort;
        bus.ACC_LD    = bus.DIN_READY && bus.DIN_VALID;
        bus.ACC_D     = state == LOAD ? bus.DIN : '0;
        bus.ACC_CLR   = RST || state == CLEAR || abort;
    end
    always_ff @(posedge clk) begin
        if (RST) begin
            remaining  <= '0;
            sticky     <= 1'b0;
            bus.RESULT <= '0;
            bus.OVF    <= 1'b0;
            bus.DONE   <= 1'b0;
        end else begin
            bus.DONE <= state == FINISH && !abort;
            if (state == IDLE && bus.START) begin
                remaining <= bus.COUNT;
                sticky    <= 1'b0;
            end
            if (bus.ACC_LD) begin
                remaining <= remaining - CNT_W'(1);
                sticky    <= sticky | carry;
            end
            if (state == FINISH && !abort) begin
                bus.RESULT <= bus.ACC_Q;
                bus.OVF    <= sticky;
            end
        end
    end
endmodule

// File: tb/tb_accum_sequencer.sv
// tb_accum_sequencer: directed and random jobs against a behavioural sum model
module tb_accum_sequencer;
    import accum_pkg::*;
    logic clk = 1'b0;
    logic RST = 1'b1;
    always #5 clk = ~clk;
    accum_sequencer_if bus ();
    accum_sequencer dut (.clk(clk), .RST(RST), .bus(bus));
    logic [7:0] acc;
    always @(posedge clk) acc <= bus.ACC_CLR ? 8'd0 : bus.ACC_LD ? acc + bus.ACC_D : acc;
    assign bus.ACC_Q = acc;
    int cyc, ld_cnt, clr_cnt, rdy_cnt, done_cnt, bad_cnt;
    int checks, errors;
    int ops[$];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        ld_cnt <= ld_cnt + int'(bus.ACC_LD);
        clr_cnt <= clr_cnt + int'(bus.ACC_CLR);
        rdy_cnt <= rdy_cnt + int'(bus.DIN_READY);
        done_cnt <= done_cnt + int'(bus.DONE);
        if ((bus.ACC_LD && !(bus.DIN_VALID && bus.DIN_READY)) || (bus.ACC_LD && bus.ACC_CLR))
            bad_cnt <= bad_cnt + 1;
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    // Called at a negedge; returns at the negedge where DONE is high.
    task automatic job(input int n, input int gmin, input int gmax, input bit poke);
        int total, stall, t0, ld0, clr0, rdy0, w, g;
        bit rdy;
        total = 0; stall = 0;
        ld0 = ld_cnt; clr0 = clr_cnt; rdy0 = rdy_cnt;
        bus.START = 1'b1; bus.COUNT = n[3:0]; t0 = cyc;
        @(negedge clk);
        bus.START = poke;
        for (int i = 0; i < n; i++) begin
            g = (i == 0) ? 0 : int'($urandom_range(gmax, gmin));
            bus.DIN_VALID = 1'b0;
            repeat (g) @(negedge clk);
            stall += g;
            bus.DIN = ops[i][7:0];
            bus.DIN_VALID = 1'b1;
            total += ops[i];
            w = 0;
            do begin
                #1 rdy = bus.DIN_READY;
                @(negedge clk);
                bus.START = 1'b0;
                w++;
            end while (!rdy && w < 50);
            check("accept", 32'(rdy), 1);
        end
        bus.DIN_VALID = 1'b0;
        bus.START = 1'b0;
        w = 0;
        while (!bus.DONE && w < 64) begin
            @(negedge clk);
            w++;
        end
        check("done_seen", 32'(bus.DONE), 1);
        check("latency", cyc - t0, n + 3 + stall);
        check("result", 32'(bus.RESULT), total % 256);
        check("ovf", 32'(bus.OVF), 32'(total > 255));
        check("ld_pulses", ld_cnt - ld0, n);
        check("clr_pulses", clr_cnt - clr0, 1);
        if (n == 0) check("ready_never", rdy_cnt - rdy0, 0);
    endtask
    initial begin
        logic [7:0] res0;
        logic ovf0;
        int d0, ld0, n;
        bus.START = 1'b0; bus.COUNT = '0; bus.ABORT = 1'b0; bus.DIN = '0; bus.DIN_VALID = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_clr", 32'(bus.ACC_CLR), 1);
        check("rst_busy", 32'(bus.BUSY), 0);
        check("rst_done", 32'(bus.DONE), 0);
        check("rst_result", 32'(bus.RESULT), 0);
        check("rst_ovf", 32'(bus.OVF), 0);
        check("rst_ready", 32'(bus.DIN_READY), 0);
        check("rst_ld", 32'(bus.ACC_LD), 0);
        RST = 1'b0;
        @(negedge clk);
        check("idle_clr", 32'(bus.ACC_CLR), 0);
        ops = '{10, 20, 30};
        job(3, 0, 0, 1'b0);
        @(negedge clk);
        ops = '{200, 100};
        job(2, 0, 0, 1'b0);
        ops = '{1, 2};
        job(2, 0, 0, 1'b0);
        @(negedge clk);
        ops = '{5, 6, 7};
        job(3, 4, 4, 1'b0);
        @(negedge clk);
        job(0, 0, 0, 1'b0);
        @(negedge clk);
        res0 = bus.RESULT; ovf0 = bus.OVF; d0 = done_cnt; ld0 = ld_cnt;
        bus.START = 1'b1; bus.COUNT = 4'd4;
        @(negedge clk);
        bus.START = 1'b0; bus.DIN_VALID = 1'b1; bus.DIN = 8'd11;
        @(negedge clk);
        @(negedge clk);
        bus.DIN = 8'd22;
        @(negedge clk);
        check("abort_pre_ld", ld_cnt - ld0, 2);
        bus.ABORT = 1'b1; bus.START = 1'b1;
        #1;
        check("abort_clr", 32'(bus.ACC_CLR), 1);
        check("abort_ready", 32'(bus.DIN_READY), 0);
        check("abort_ld", 32'(bus.ACC_LD), 0);
        @(negedge clk);
        bus.ABORT = 1'b0; bus.START = 1'b0; bus.DIN_VALID = 1'b0;
        check("abort_busy", 32'(bus.BUSY), 0);
        check("abort_acc", 32'(bus.ACC_Q), 0);
        repeat (6) @(negedge clk);
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_result", 32'(bus.RESULT), 32'(res0));
        check("abort_ovf", 32'(bus.OVF), 32'(ovf0));
        check("abort_idle", 32'(bus.BUSY), 0);
        for (int k = 0; k < 10; k++) begin
            n = int'($urandom_range(1, 15));
            ops.delete();
            repeat (n) ops.push_back(int'($urandom_range(0, 255)));
            if ($urandom_range(0, 1) == 1) @(negedge clk);
            job(n, 0, 2, 1'($urandom_range(0, 1)));
        end
        @(negedge clk);
        d0 = done_cnt;
        bus.START = 1'b1; bus.COUNT = 4'd5;
        @(negedge clk);
        bus.START = 1'b0; bus.DIN_VALID = 1'b1; bus.DIN = 8'd99;
        repeat (3) @(negedge clk);
        RST = 1'b1;
        #1;
        check("midrst_clr", 32'(bus.ACC_CLR), 1);
        check("midrst_ld", 32'(bus.ACC_LD), 0);
        @(negedge clk);
        RST = 1'b0; bus.DIN_VALID = 1'b0;
        #1;
        check("postrst_busy", 32'(bus.BUSY), 0);
        check("postrst_done", 32'(bus.DONE), 0);
        check("postrst_result", 32'(bus.RESULT), 0);
        check("postrst_ovf", 32'(bus.OVF), 0);
        check("postrst_ready", 32'(bus.DIN_READY), 0);
        check("postrst_acc", 32'(bus.ACC_Q), 0);
        repeat (4) @(negedge clk);
        check("postrst_no_done", done_cnt - d0, 0);
        ops = '{128, 64, 100, 3};
        job(4, 0, 1, 1'b0);
        check("no_illegal_ld", bad_cnt, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
